car_sensor_driver: RTL



---
 rtl/car_sensor_pkg.sv | 33 +++
 rtl/car_sensor_driver_if.sv | 25 ++
 rtl/sensor_req_fifo.sv | 39 +++
 rtl/car_sensor_driver.sv | 104 ++++++++++
 4 files changed

// File: rtl/car_sensor_pkg.sv
// Shared types and beam-pattern decode for the parking-lot sensor stimulus driver.
package car_sensor_pkg;

  typedef enum logic {
    DIR_ENTER = 1'b0,
    DIR_EXIT  = 1'b1
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    P1,
    P2,
    P3,
    P4
  } drv_state_t;

  // {outer,inner} for P1..P4, most-significant pair first
  localparam logic [7:0] PAT_ENTER = 8'b10_11_01_00;
  localparam logic [7:0] PAT_EXIT  = 8'b01_11_10_00;

  function automatic logic [1:0] beam_pattern(input drv_state_t s, input dir_t d);
    logic [7:0] p;
    p = (d == DIR_EXIT) ? PAT_EXIT : PAT_ENTER;
    case (s)
      P1:      return p[7:6];
      P2:      return p[5:4];
      P3:      return p[3:2];
      P4:      return p[1:0];
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/car_sensor_driver_if.sv
// Request handshake and beam/status outputs of the sensor stimulus driver.
interface car_sensor_driver_if #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
);
  logic               req_valid;
  logic               req_dir;
  logic               req_ready;
  logic [DWELL_W-1:0] dwell;
  logic               outer;
  logic               inner;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   cars_sent;

  modport master (
    output req_valid, req_dir, dwell,
    input  req_ready, outer, inner, busy, done, cars_sent
  );

  modport slave (
    input  req_valid, req_dir, dwell,
    output req_ready, outer, inner, busy, done, cars_sent
  );
endinterface

// File: rtl/sensor_req_fifo.sv
// Direction-request FIFO; pointers carry an extra wrap bit to tell full from empty.
module sensor_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [DEPTH-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wptr_q[AW-1:0]] <= din;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/car_sensor_driver.sv
// Replays queued enter/exit requests as outer/inner beam waveforms, L cycles per phase.
module car_sensor_driver
  import car_sensor_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  car_sensor_driver_if.slave  bus
);

  drv_state_t         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] len_q, len_d;
  dir_t               dir_q, dir_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cars_q, cars_d;

  logic               push, pop, load;
  logic               fifo_dout, fifo_full, fifo_empty;
  logic [DWELL_W-1:0] dwell_eff;

  assign push          = bus.req_valid && !fifo_full;
  assign bus.req_ready = !fifo_full;
  assign dwell_eff     = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

  sensor_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.req_dir),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      dir_q   <= DIR_ENTER;
      done_q  <= 1'b0;
      cars_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      cars_q  <= cars_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    cars_d  = cars_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: load = !fifo_empty;
      P1, P2, P3: begin
        if (cnt_q == '0) begin
          state_d = (state_q == P1) ? P2 : (state_q == P2) ? P3 : P4;
          cnt_d   = len_q - DWELL_W'(1);
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      P4: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          cars_d = cars_q + CNT_W'(1);
          if (!fifo_empty) load = 1'b1;
          else             state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Shared by IDLE start and back-to-back chaining out of P4
    if (load) begin
      pop     = 1'b1;
      state_d = P1;
      dir_d   = dir_t'(fifo_dout);
      len_d   = dwell_eff;
      cnt_d   = dwell_eff - DWELL_W'(1);
    end
  end

  assign {bus.outer, bus.inner} = beam_pattern(state_q, dir_q);
  assign bus.busy               = (state_q != IDLE);
  assign bus.done               = done_q;
  assign bus.cars_sent          = cars_q;

endmodule
